// File: rtl/segway_uart_pkg.sv
// Shared definitions for the UART command path.
//   asm_state_t : state of the byte-pair assembler
//   CMD_W       : width of an assembled command word
//   BYTE_W      : width of one received UART byte
package segway_uart_pkg;

  typedef enum logic {
    IDLE     = 1'b0,   // awaiting the high byte
    WAIT_LOW = 1'b1    // high byte held, awaiting the low byte
  } asm_state_t;

  localparam int CMD_W  = 16;
  localparam int BYTE_W = 8;

endpackage

// File: rtl/uart_cmd_assembler_timeout_timer.sv
// Loadable down-counter bounding the gap between the two bytes of a command.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (counter clears to 0)
//   load       : reload the counter with TIMEOUT_CYCLES-1 (wins over en)
//   en         : count down by one while non-zero
//   expired    : counter is at zero while enabled (combinational)
module timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TMR_W'(TIMEOUT_CYCLES - 1);
    end else if (en && (cnt != '0)) begin
      // Holds at zero rather than wrapping.
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign expired = (cnt == '0) & en;

endmodule

// File: rtl/uart_cmd_assembler.sv
// Pairs bytes from the UART receiver, high byte first, into 16-bit commands.
//
// Handshake (receiver side): rx_rdy is a level that stays high until the
// receiver sees clr_rx_rdy at a clock edge. clr_rx_rdy is a combinational
// one-cycle pulse raised in the same cycle rx_rdy is seen, so each byte is
// consumed exactly once. Handshake (consumer side): cmd_rdy is a level held
// until clr_cmd_rdy is seen at a clock edge; cmd stays stable while cmd_rdy=1
// unless a newer command overwrites it (flagged by overrun).
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   rx_rdy       : receiver byte valid (level)
//   rx_data      : received byte
//   clr_rx_rdy   : consumes the current byte (combinational)
//   clr_cmd_rdy  : consumer acknowledge of cmd
//   cmd          : assembled command {high, low}
//   cmd_rdy      : command valid (level)
//   overrun      : one-cycle pulse, new command replaced an unacknowledged one
//   frame_err    : one-cycle pulse, low byte did not arrive in time
module uart_cmd_assembler
  import segway_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              clr_rx_rdy,
  input  logic              clr_cmd_rdy,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  output logic              overrun,
  output logic              frame_err
);

  asm_state_t        state;
  logic [BYTE_W-1:0] high_byte;
  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_expired;

  // Both states accept a byte, so a byte is taken whenever one is offered.
  assign clr_rx_rdy = rx_rdy & ((state == IDLE) || (state == WAIT_LOW));

  // Timer starts on high-byte capture and only runs while the low byte is
  // absent; an arriving byte therefore masks expiry in the race cycle.
  assign tmr_load = (state == IDLE) & rx_rdy;
  assign tmr_en   = (state == WAIT_LOW) & ~rx_rdy;

  timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      high_byte <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      // Acknowledge first; a completion below overrides it.
      if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_rdy) begin
            high_byte <= rx_data;
            state     <= WAIT_LOW;
          end
        end

        WAIT_LOW: begin
          if (rx_rdy) begin
            cmd     <= {high_byte, rx_data};
            cmd_rdy <= 1'b1;
            // An acknowledge in the same cycle retires the old command,
            // so nothing is lost.
            overrun <= cmd_rdy & ~clr_cmd_rdy;
            state   <= IDLE;
          end else if (tmr_expired) begin
            frame_err <= 1'b1;
            high_byte <= '0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler with TIMEOUT_CYCLES=100.
// Expected {overrun, cmd} words are queued by the stimulus; a monitor pops
// and compares each time a new command is presented.
module tb_uart_cmd_assembler;

  localparam int TO = 100;
  localparam int W  = 17;   // {overrun, cmd}

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        overrun;
  logic        frame_err;

  logic [W-1:0] exp_q[$];

  int checks;
  int errors;
  int cycle;
  int clr_count;
  int ov_count;
  int fe_count;
  int fe_cycle;
  logic        prev_rdy;
  logic [15:0] prev_cmd;

  uart_cmd_assembler #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Models the receiver: rx_rdy rises mid-cycle and drops after the edge
  // on which clr_rx_rdy was seen.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    check("clr_rx_rdy_on_byte", clr_rx_rdy, 1'b1);
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
  endtask

  task automatic send_cmd(input logic [15:0] c, input logic ov);
    exp_q.push_back({ov, c});
    send_byte(c[15:8]);
    send_byte(c[7:0]);
  endtask

  task automatic ack();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rdy = 1'b0;
      prev_cmd = '0;
    end else begin
      if (clr_rx_rdy) clr_count++;
      if (overrun) ov_count++;
      if (frame_err) begin
        fe_count++;
        fe_cycle = cycle;
      end
      if (cmd_rdy && (!prev_rdy || (cmd != prev_cmd) || overrun)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd actual=%0h expected=none at cycle %0d", {overrun, cmd}, cycle);
        end else begin
          check("cmd_word", {15'd0, overrun, cmd}, {15'd0, exp_q.pop_front()});
        end
      end
      prev_rdy = cmd_rdy;
      prev_cmd = cmd;
    end
  end

  // Bounded run time.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  int c0;
  int clr0;
  int ov0;
  int fe0;

  initial begin
    checks = 0; errors = 0; cycle = 0;
    clr_count = 0; ov_count = 0; fe_count = 0; fe_cycle = 0;
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_cmd", cmd, 16'h0000);
    check("reset_cmd_rdy", cmd_rdy, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_clr_rx_rdy", clr_rx_rdy, 1'b0);

    // Basic pair, 20 clocks apart.
    clr0 = clr_count; ov0 = ov_count; fe0 = fe_count;
    exp_q.push_back({1'b0, 16'hA53C});
    send_byte(8'hA5);
    repeat (20) @(posedge clk);
    check("cmd_rdy_before_low", cmd_rdy, 1'b0);
    send_byte(8'h3C);
    check("cmd_rdy_latency", cmd_rdy, 1'b1);
    repeat (3) @(posedge clk);
    check("clr_pulse_count", clr_count - clr0, 2);
    check("basic_no_overrun", ov_count - ov0, 0);
    check("basic_no_frame_err", fe_count - fe0, 0);
    ack();
    #1;
    check("ack_clears_cmd_rdy", cmd_rdy, 1'b0);
    check("ack_cmd_held", cmd, 16'hA53C);

    // Back-to-back without acknowledge.
    ov0 = ov_count;
    send_cmd(16'h1234, 1'b0);
    send_cmd(16'h5678, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_cmd", cmd, 16'h5678);
    check("b2b_cmd_rdy_held", cmd_rdy, 1'b1);
    check("b2b_overrun_once", ov_count - ov0, 1);
    ack();

    // Timeout on a lone high byte, then resync.
    fe0 = fe_count;
    send_byte(8'hFF);
    c0 = cycle;
    repeat (TO + 1) @(posedge clk);
    #1;
    check("timeout_frame_err_once", fe_count - fe0, 1);
    check("timeout_frame_err_cycle", fe_cycle - c0, TO);
    check("timeout_cmd_rdy_unchanged", cmd_rdy, 1'b0);
    check("timeout_cmd_unchanged", cmd, 16'h5678);
    send_cmd(16'h0102, 1'b0);
    ack();

    // Low byte arrives in the cycle the timer reaches zero.
    fe0 = fe_count;
    exp_q.push_back({1'b0, 16'hABCD});
    send_byte(8'hAB);
    repeat (TO - 1) @(posedge clk);
    send_byte(8'hCD);
    repeat (5) @(posedge clk);
    #1;
    check("race_no_frame_err", fe_count - fe0, 0);
    check("race_cmd", cmd, 16'hABCD);

    // Completion and acknowledge in the same cycle (cmd_rdy still 1).
    ov0 = ov_count;
    exp_q.push_back({1'b0, 16'h9ABC});
    send_byte(8'h9A);
    @(negedge clk);
    rx_data = 8'hBC;
    rx_rdy = 1'b1;
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    check("set_clr_cmd_rdy", cmd_rdy, 1'b1);
    repeat (2) @(posedge clk);
    check("set_clr_no_overrun", ov_count - ov0, 0);
    ack();
    #1;
    check("clr_alone_cmd_rdy", cmd_rdy, 1'b0);
    check("clr_alone_cmd", cmd, 16'h9ABC);

    // Reset in WAIT_LOW drops the partial byte.
    send_byte(8'h77);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_cmd", cmd, 16'h0000);
    check("midreset_cmd_rdy", cmd_rdy, 1'b0);
    check("midreset_overrun", overrun, 1'b0);
    check("midreset_frame_err", frame_err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_cmd(16'h1122, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_cmd", cmd, 16'h1122);

    // Wrap-up.
    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("total_overrun", ov_count, 1);
    check("total_frame_err", fe_count, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
